axis_decimating_averager: RTL and testbench
===========================================

Name: axis_decimating_averager

Overview:
- Block-averaging decimator placed directly downstream of the IIR filter stage.
- Consumes the filter's signed 16-bit AXI-Stream samples and sums R consecutive samples, where R is the runtime decimation ratio.
- Emits one arithmetically shifted, saturated signed sample per block.
- Output feeds the DMA/packetizer stages at the reduced rate.

Parameters:
AXIS_TDATA_WIDTH, 16, sample width in and out (signed two's complement)
CNTR_WIDTH, 16, width of decimation ratio and sample counter
ACC_WIDTH, AXIS_TDATA_WIDTH+CNTR_WIDTH, accumulator width (full growth for R up to 2^CNTR_WIDTH-1)

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous active-high reset
cfg_ratio  in  CNTR_WIDTH  decimation ratio R; values 0 and 1 both mean R=1
cfg_shift  in  6  right arithmetic shift applied to the block sum; clamped to ACC_WIDTH-1
s_axis_tdata  in  AXIS_TDATA_WIDTH  input sample
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  AXIS_TDATA_WIDTH  averaged sample
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready

Behaviour:
- Reset (areset=1 at a clock edge): acc=0, cnt=0, m_axis_tvalid=0, m_axis_tdata=0, int_ratio=cfg_ratio (0 becomes 1), int_shift=clamped cfg_shift. Reset mid-block discards the partial sum and any pending output.
- Config sampling: int_ratio and int_shift reload only on reset and on the cycle a block completes. Changes to cfg_* mid-block take effect at the next block boundary.
- Input accept: transfer when s_axis_tvalid & s_axis_tready.
- Block sum: cnt counts accepted samples 0..int_ratio-1. The block sum is acc + sign-extended s_axis_tdata, computed at full ACC_WIDTH with no overflow possible.
- Non-final sample (cnt != int_ratio-1): acc <= sum, cnt <= cnt+1.
- Final sample (cnt == int_ratio-1), one clock edge:
  - m_axis_tdata <= sat(sum >>> int_shift); m_axis_tvalid <= 1; acc <= 0; cnt <= 0; config reloads.
  - Latency: 1 cycle from the last accepted sample to m_axis_tvalid high.
- Saturation: results above 2^(W-1)-1 clamp to 0x7FFF; results below -2^(W-1) clamp to 0x8000 (W=16).
- Output register: single entry, cleared on m_axis_tvalid & m_axis_tready. m_axis_tdata holds stable while valid is high and ready is low.
- Backpressure:
  - s_axis_tready = ~(cnt == int_ratio-1) | ~m_axis_tvalid | m_axis_tready.
  - Only a block-completing sample can stall; accumulation of non-final samples never stalls.
  - s_axis_tready has a combinational path from m_axis_tready.
- Simultaneous events:
  - Output drain and new block completion in the same cycle: new result loads and m_axis_tvalid stays 1, giving full throughput at R=1.
  - Drain without completion: m_axis_tvalid <= 0.
- R=1: every accepted sample produces an output equal to sat(sample >>> int_shift).
- s_axis_tvalid low: no state change except the output drain.

Optional Feature:
- Macro: AXIS_DECIMATING_AVERAGER_ROUND_EN.
- Defined: before the shift, add 2^(int_shift-1) when int_shift>0 (round half up), then saturate. The rounding addend uses ACC_WIDTH+1 bits internally so it cannot overflow.
- Undefined: plain truncation toward minus infinity via arithmetic shift. No extra adder.

Test Plan:
- R=4, shift=2, m_axis_tready=1, inputs 100,200,300,400 -> one output of 250, one cycle after the 4th sample. No other outputs.
- R=1, shift=0, continuous valid, inputs -5,7,32767 -> outputs -5,7,32767 on consecutive cycles. s_axis_tready stays high throughout.
- R=2, shift=0, inputs 32767,32767 -> 0x7FFF (saturated); inputs -32768,-32768 -> 0x8000.
- R=2, shift=0, m_axis_tready=0 after the first output is pending:
  - A completing sample sees s_axis_tready=0 and stalls.
  - Non-final samples are still accepted.
  - On raising ready, the held value is read first, then the stalled sample completes.
- Mid-block config change: R=3 latched, cfg_ratio changed to 2 after the 1st sample -> current block uses 3 samples, next block uses 2.
- Reset after 2 of 4 samples -> m_axis_tvalid=0, m_axis_tdata=0. The next 4 inputs 4,4,4,4 with shift=2 -> output 4.
- With AXIS_DECIMATING_AVERAGER_ROUND_EN, R=2, shift=1, inputs 1,2 -> output 2; without the macro -> output 1.

Source files
------------

// File: rtl/axis_decimating_averager_if.sv
// ----------------------------------------------------------------------------
// axis_decimating_averager_if
//
// Minimal AXI-Stream bundle used on both sides of the decimating averager.
//
// Signals:
//   tdata   sample payload, DATA_WIDTH bits (signed two's complement by use)
//   tvalid  producer has a sample on tdata
//   tready  consumer can take the sample this cycle
//
// Modports:
//   master  drives tdata/tvalid, observes tready (stream source)
//   slave   observes tdata/tvalid, drives tready (stream sink)
// ----------------------------------------------------------------------------
interface axis_decimating_averager_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_decimating_averager.sv
// ----------------------------------------------------------------------------
// axis_decimating_averager
//
// Block-averaging decimator that sits right after the IIR filter stage. It
// adds up R consecutive signed input samples (R = runtime decimation ratio),
// arithmetically shifts the block sum right, saturates the result to the
// sample width and emits one sample per block towards the DMA/packetizer.
//
// Ports:
//   aclk       clock, all logic on the rising edge
//   areset     synchronous active-high reset
//   cfg_ratio  decimation ratio R (0 and 1 both mean R=1), sampled at reset
//              and whenever a block completes
//   cfg_shift  right arithmetic shift for the block sum, clamped to
//              ACC_WIDTH-1, sampled together with cfg_ratio
//   s_axis     input sample stream (slave modport)
//   m_axis     averaged output stream (master modport)
//
// Optional build macro:
//   AXIS_DECIMATING_AVERAGER_ROUND_EN - when defined, adds 2^(shift-1) to the
//   block sum before shifting (round half up). When undefined the shift
//   truncates toward minus infinity and no rounding adder exists.
// ----------------------------------------------------------------------------
module axis_decimating_averager #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CNTR_WIDTH       = 16,
    parameter int ACC_WIDTH        = AXIS_TDATA_WIDTH + CNTR_WIDTH
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_ratio,
    input  logic [5:0]                  cfg_shift,
    axis_decimating_averager_if.slave   s_axis,
    axis_decimating_averager_if.master  m_axis
);

    localparam int W = AXIS_TDATA_WIDTH;

`ifdef AXIS_DECIMATING_AVERAGER_ROUND_EN
    // One guard bit so the rounding addend can never wrap the sum.
    localparam int RW = ACC_WIDTH + 1;
`else
    localparam int RW = ACC_WIDTH;
`endif

    localparam logic [5:0] SHIFT_MAX = 6'(ACC_WIDTH - 1);

    // Saturation limits expressed at the width of the shifted result.
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic        [CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic        [CNTR_WIDTH-1:0] ratio_q, ratio_d;
    logic        [5:0]            shift_q, shift_d;
    logic        [W-1:0]          out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;

    logic        [CNTR_WIDTH-1:0] cfg_ratio_eff;
    logic        [5:0]            cfg_shift_eff;
    logic                         last_sample;
    logic                         s_ready;
    logic                         accept;
    logic signed [ACC_WIDTH-1:0]  in_ext;
    logic signed [ACC_WIDTH-1:0]  block_sum;
    logic signed [RW-1:0]         pre_shift;
    logic signed [RW-1:0]         shifted;
    logic        [W-1:0]          sat_result;

    // Configuration decode: a ratio of 0 is treated as 1 and oversized
    // shifts are limited so the shifter never runs past the sign bit.
    always_comb begin
        cfg_ratio_eff = cfg_ratio;
        if (cfg_ratio == '0) begin
            cfg_ratio_eff = CNTR_WIDTH'(1);
        end
        cfg_shift_eff = cfg_shift;
        if (cfg_shift > SHIFT_MAX) begin
            cfg_shift_eff = SHIFT_MAX;
        end
    end

    // Only the block-completing sample can be held off, and only while an
    // undrained result occupies the output register. m_axis.tready feeds
    // straight through so a drain and a completion can share one cycle.
    always_comb begin
        last_sample = (cnt_q == (ratio_q - CNTR_WIDTH'(1)));
        s_ready     = ~last_sample | ~out_valid_q | m_axis.tready;
        accept      = s_axis.tvalid & s_ready;
        in_ext      = {{(ACC_WIDTH-W){s_axis.tdata[W-1]}}, s_axis.tdata};
        block_sum   = acc_q + in_ext;
    end

    // Scale the block sum and clamp it into the signed sample range.
    always_comb begin
`ifdef AXIS_DECIMATING_AVERAGER_ROUND_EN
        pre_shift = {block_sum[ACC_WIDTH-1], block_sum};
        if (shift_q != 6'd0) begin
            pre_shift = pre_shift + (RW'(1) << (shift_q - 6'd1));
        end
`else
        pre_shift = block_sum;
`endif
        shifted = pre_shift >>> shift_q;
        if (shifted > SAT_MAX) begin
            sat_result = {1'b0, {(W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat_result = {1'b1, {(W-1){1'b0}}};
        end else begin
            sat_result = shifted[W-1:0];
        end
    end

    // Next-state: the output drain is applied first so that a completion in
    // the same cycle overrides it and keeps the output valid.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ratio_d     = ratio_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && m_axis.tready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (last_sample) begin
                out_data_d  = sat_result;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                ratio_d     = cfg_ratio_eff;
                shift_d     = cfg_shift_eff;
            end else begin
                acc_d = block_sum;
                cnt_d = cnt_q + CNTR_WIDTH'(1);
            end
        end
    end

    // State registers; reset drops any partial block and pending output and
    // reloads the configuration.
    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ratio_q     <= cfg_ratio_eff;
            shift_q     <= cfg_shift_eff;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ratio_q     <= ratio_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tvalid = out_valid_q;

endmodule

// File: tb/tb_axis_decimating_averager.sv
// ----------------------------------------------------------------------------
// tb_axis_decimating_averager
//
// Directed scoreboard bench for axis_decimating_averager. The stimulus
// process pushes the hand-computed result of each block into a queue before
// feeding its final sample; a separate monitor pops and compares every
// output handshake. Inputs change #1 after the rising edge, outputs are
// sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_axis_decimating_averager;

    logic        aclk;
    logic        areset;
    logic [15:0] cfg_ratio;
    logic [5:0]  cfg_shift;

    axis_decimating_averager_if #(.DATA_WIDTH(16)) s_if ();
    axis_decimating_averager_if #(.DATA_WIDTH(16)) m_if ();

    axis_decimating_averager #(
        .AXIS_TDATA_WIDTH (16),
        .CNTR_WIDTH       (16),
        .ACC_WIDTH        (32)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .cfg_ratio (cfg_ratio),
        .cfg_shift (cfg_shift),
        .s_axis    (s_if.slave),
        .m_axis    (m_if.master)
    );

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] exp_q[$];
    int          stalls;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Global time limit so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard monitor: every output handshake must match the oldest
    // expected result.
    initial begin
        forever begin
            @(negedge aclk);
            if (!areset && m_if.tvalid && m_if.tready) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_output: got %0d, expected none",
                             $signed(m_if.tdata));
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (m_if.tdata !== e) begin
                        mismatched++;
                        $display("[TB] FAIL output_value: got %0d (0x%04h), expected %0d (0x%04h)",
                                 $signed(m_if.tdata), m_if.tdata, $signed(e), e);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input int value);
        exp_q.push_back(16'(value));
    endtask

    // Present one sample and wait (bounded) until it is accepted; returns
    // with tvalid still high, #1 after the accepting edge.
    task automatic applyStimulus(input int value, output int waited);
        waited = 0;
        s_if.tdata  = 16'(value);
        s_if.tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_if.tready) break;
            waited++;
            if (waited >= 50) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL accept_timeout: sample %0d not accepted in 50 cycles", value);
                break;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int cycles);
        s_if.tvalid = 1'b0;
        repeat (cycles) @(posedge aclk);
        #1;
    endtask

    task automatic doReset(input int ratio, input int shift);
        s_if.tvalid = 1'b0;
        cfg_ratio   = 16'(ratio);
        cfg_shift   = 6'(shift);
        areset      = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    initial begin
        areset      = 1'b1;
        cfg_ratio   = 16'd4;
        cfg_shift   = 6'd2;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // Reset state.
        doReset(4, 2);
        @(negedge aclk);
        checkOutput("reset_tvalid", 32'(m_if.tvalid), 32'd0);
        checkOutput("reset_tdata", 32'(m_if.tdata), 32'd0);
        checkOutput("reset_tready", 32'(s_if.tready), 32'd1);
        @(posedge aclk);
        #1;

        // R=4, shift=2: (100+200+300+400)>>2 = 250, one cycle after the last sample.
        $display("[TB] block average R=4");
        applyStimulus(100, stalls);
        applyStimulus(200, stalls);
        applyStimulus(300, stalls);
        checkOutput("r4_no_early_output", 32'(m_if.tvalid), 32'd0);
        pushExpected(250);
        applyStimulus(400, stalls);
        s_if.tvalid = 1'b0;
        @(negedge aclk);
        checkOutput("r4_latency_tvalid", 32'(m_if.tvalid), 32'd1);
        idle(3);

        // R=0 behaves as R=1, continuous valid, no stalls.
        $display("[TB] pass-through R=0/1");
        doReset(0, 0);
        pushExpected(-5);
        applyStimulus(-5, stalls);
        checkOutput("r1_stall_0", 32'(stalls), 32'd0);
        pushExpected(7);
        applyStimulus(7, stalls);
        checkOutput("r1_stall_1", 32'(stalls), 32'd0);
        pushExpected(32767);
        applyStimulus(32767, stalls);
        checkOutput("r1_stall_2", 32'(stalls), 32'd0);
        idle(3);

        // Saturation at both ends with R=2.
        $display("[TB] saturation R=2");
        doReset(2, 0);
        applyStimulus(32767, stalls);
        pushExpected(32767);
        applyStimulus(32767, stalls);
        applyStimulus(-32768, stalls);
        pushExpected(-32768);
        applyStimulus(-32768, stalls);
        idle(3);

        // Backpressure with R=2: 10+20 = 30 held, 1 accepted, 2 stalls.
        $display("[TB] backpressure R=2");
        doReset(2, 0);
        m_if.tready = 1'b0;
        pushExpected(30);
        applyStimulus(10, stalls);
        applyStimulus(20, stalls);
        applyStimulus(1, stalls);
        checkOutput("bp_nonfinal_no_stall", 32'(stalls), 32'd0);
        s_if.tdata = 16'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checkOutput("bp_final_stalled", 32'(s_if.tready), 32'd0);
            checkOutput("bp_tdata_held", 32'(m_if.tdata), 32'd30);
        end
        @(posedge aclk);
        #1;
        m_if.tready = 1'b1;
        pushExpected(3);
        applyStimulus(2, stalls);
        s_if.tvalid = 1'b0;
        @(negedge aclk);
        checkOutput("bp_second_valid", 32'(m_if.tvalid), 32'd1);
        idle(3);

        // Mid-block ratio change: current block keeps R=3, next uses R=2.
        $display("[TB] config change at block boundary");
        doReset(3, 0);
        applyStimulus(1, stalls);
        cfg_ratio = 16'd2;
        applyStimulus(2, stalls);
        pushExpected(6);
        applyStimulus(3, stalls);
        applyStimulus(4, stalls);
        pushExpected(9);
        applyStimulus(5, stalls);
        idle(3);

        // Reset mid-block with a pending output discards both.
        $display("[TB] reset mid-block");
        doReset(4, 2);
        m_if.tready = 1'b0;
        applyStimulus(8, stalls);
        applyStimulus(8, stalls);
        applyStimulus(8, stalls);
        applyStimulus(8, stalls);
        applyStimulus(1, stalls);
        applyStimulus(1, stalls);
        s_if.tvalid = 1'b0;
        @(negedge aclk);
        checkOutput("pre_reset_tvalid", 32'(m_if.tvalid), 32'd1);
        @(posedge aclk);
        #1;
        doReset(4, 2);
        @(negedge aclk);
        checkOutput("midreset_tvalid", 32'(m_if.tvalid), 32'd0);
        checkOutput("midreset_tdata", 32'(m_if.tdata), 32'd0);
        @(posedge aclk);
        #1;
        m_if.tready = 1'b1;
        applyStimulus(4, stalls);
        applyStimulus(4, stalls);
        applyStimulus(4, stalls);
        pushExpected(4);
        applyStimulus(4, stalls);
        idle(3);

        // Shift clamp (63 -> 31) and negative shifting with R=1.
        $display("[TB] shift clamp and negative values");
        doReset(1, 63);
`ifdef AXIS_DECIMATING_AVERAGER_ROUND_EN
        pushExpected(0);
`else
        pushExpected(-1);
`endif
        applyStimulus(-1, stalls);
        pushExpected(0);
        applyStimulus(100, stalls);
        cfg_shift = 6'd1;
        idle(2);
        doReset(1, 1);
`ifdef AXIS_DECIMATING_AVERAGER_ROUND_EN
        pushExpected(-1);
`else
        pushExpected(-2);
`endif
        applyStimulus(-3, stalls);
        idle(3);

        // Rounding: R=2, shift=1, 1+2=3 -> 2 rounded, 1 truncated.
        $display("[TB] rounding option");
        doReset(2, 1);
        applyStimulus(1, stalls);
`ifdef AXIS_DECIMATING_AVERAGER_ROUND_EN
        pushExpected(2);
`else
        pushExpected(1);
`endif
        applyStimulus(2, stalls);
        idle(5);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
